// File: rtl/score_bcd_counter.sv
// Four-digit packed-BCD score counter with saturation, high-score tracking and a
// one-entry pending slot so add requests arriving mid-sequence are not lost.
`timescale 1ns/1ps

module score_bcd_counter #(
    parameter logic [15:0] SAT_VALUE = 16'h9999
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add_pulse,
    input  logic [3:0]  add_value,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        busy,
    output logic        saturated,
    output logic        drop_err
);

    // IDLE: waiting | ADD0..ADD3: ripple one digit per cycle | COMMIT: write score
    typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT} state_t;

    state_t      state;
    logic        start;
    logic [3:0]  addend;
    logic [15:0] work;
    logic        carry;
    logic        pend_valid;
    logic [3:0]  pend_value;

    logic [3:0]  clamped;
    logic        occupied;
    logic [1:0]  digit_idx;
    logic [3:0]  digit_in;
    logic [4:0]  digit_sum;
    logic [4:0]  digit_adj;
    logic        digit_carry;
    logic [15:0] commit_value;

    assign clamped  = (add_value > 4'd9) ? 4'd9 : add_value;
    // start and an unconsumed slot both mean a sequence is already claimed
    assign occupied = busy || start || pend_valid;

    always_comb begin
        digit_idx = 2'd0;
        case (state)
            ADD1:    digit_idx = 2'd1;
            ADD2:    digit_idx = 2'd2;
            ADD3:    digit_idx = 2'd3;
            default: digit_idx = 2'd0;
        endcase
        digit_in     = work[{digit_idx, 2'b00} +: 4];
        digit_sum    = {1'b0, digit_in} + {4'd0, carry}
                     + ((state == ADD0) ? {1'b0, addend} : 5'd0);
        digit_carry  = (digit_sum > 5'd9);
        digit_adj    = digit_sum - 5'd10;
        commit_value = (carry || saturated) ? SAT_VALUE : work;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state      <= IDLE;
            start      <= 1'b0;
            addend     <= 4'd0;
            work       <= 16'd0;
            carry      <= 1'b0;
            pend_valid <= 1'b0;
            pend_value <= 4'd0;
            score      <= 16'd0;
            high_score <= 16'd0;
            busy       <= 1'b0;
            saturated  <= 1'b0;
            drop_err   <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            start      <= 1'b0;
            carry      <= 1'b0;
            pend_valid <= 1'b0;
            score      <= 16'd0;
            busy       <= 1'b0;
            saturated  <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (add_pulse && occupied) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_value <= clamped;
                end else begin
                    drop_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        start <= 1'b0;
                        state <= ADD0;
                        busy  <= 1'b1;
                        work  <= score;
                        carry <= 1'b0;
                    end else if (pend_valid) begin
                        pend_valid <= 1'b0;
                        addend     <= pend_value;
                        state      <= ADD0;
                        busy       <= 1'b1;
                        work       <= score;
                        carry      <= 1'b0;
                    end else if (add_pulse) begin
                        start  <= 1'b1;
                        addend <= clamped;
                    end
                end
                ADD0, ADD1, ADD2, ADD3: begin
                    work[{digit_idx, 2'b00} +: 4] <= digit_carry ? digit_adj[3:0] : digit_sum[3:0];
                    carry <= digit_carry;
                    case (state)
                        ADD0:    state <= ADD1;
                        ADD1:    state <= ADD2;
                        ADD2:    state <= ADD3;
                        default: state <= COMMIT;
                    endcase
                end
                COMMIT: begin
                    score <= commit_value;
                    if (commit_value > high_score) high_score <= commit_value;
                    if (carry) saturated <= 1'b1;
                    if (pend_valid) begin
                        // chain straight into the next add using the value being committed
                        pend_valid <= 1'b0;
                        addend     <= pend_value;
                        work       <= commit_value;
                        carry      <= 1'b0;
                        state      <= ADD0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter: a decimal-arithmetic model schedules
// commits by edge number; a monitor checks outputs every cycle against it.
`timescale 1ns/1ps

module tb_score_bcd_counter;

    localparam int MAXE    = 20000;
    localparam int SAT_DEC = 9999;

    logic        CLK100MHZ = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clear     = 1'b0;
    logic        add_pulse = 1'b0;
    logic [3:0]  add_value = 4'd0;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        busy;
    logic        saturated;
    logic        drop_err;

    score_bcd_counter dut (
        .CLK100MHZ (CLK100MHZ),
        .rst_n     (rst_n),
        .clear     (clear),
        .add_pulse (add_pulse),
        .add_value (add_value),
        .score     (score),
        .high_score(high_score),
        .busy      (busy),
        .saturated (saturated),
        .drop_err  (drop_err)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int edge_cnt = 0;
    always @(posedge CLK100MHZ) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          e;
        logic [15:0] score;
        logic [15:0] high;
        logic        sat;
    } exp_t;

    exp_t sbq[$];
    bit   exp_busy [MAXE];
    bit   exp_drop [MAXE];

    int checks = 0;
    int errors = 0;

    // reference model state (decimal values, edge-numbered schedule)
    int m_score = 0, m_high = 0;
    bit m_sat = 0, m_drop = 0;
    int cur_commit = -1, cur_val = 0;
    bit slot_full = 0;
    int slot_edge = 0, slot_val = 0, slot_release = -1;
    int last_edge = 0;
    bit done = 0;

    function automatic logic [15:0] to_bcd(int d);
        logic [15:0] r;
        int x;
        x = d;
        r = 16'd0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic set_busy(int from, int to, bit val);
        for (int e = from; e <= to; e++) if (e >= 0 && e < MAXE) exp_busy[e] = val;
    endtask

    task automatic push_exp(int c);
        exp_t x;
        x.e = c; x.score = to_bcd(m_score); x.high = to_bcd(m_high); x.sat = m_sat;
        sbq.push_back(x);
    endtask

    task automatic model_edge(int c, bit p, int v, bit cl, bit rs);
        int total;
        int cv;
        cv = (v > 9) ? 9 : v;
        if (!rs) begin
            m_score = 0; m_high = 0; m_sat = 0; m_drop = 0;
            cur_commit = -1; slot_full = 0; slot_release = -1;
            set_busy(c, c + 12, 0);
            push_exp(c);
        end else if (cl) begin
            m_score = 0; m_sat = 0; m_drop = 0;
            cur_commit = -1; slot_full = 0; slot_release = -1;
            set_busy(c, c + 12, 0);
            push_exp(c);
        end else begin
            if (p) begin
                if (cur_commit >= c) begin
                    if (slot_full) m_drop = 1;
                    else begin slot_full = 1; slot_edge = c; slot_val = cv; end
                end else begin
                    cur_commit = c + 6; cur_val = cv;
                    set_busy(c + 1, c + 5, 1);
                end
            end
            if (slot_full && slot_release == c) begin
                slot_full = 0; slot_release = -1;
            end
            if (c == cur_commit) begin
                total = m_score + cur_val;
                if (m_sat || total > SAT_DEC) begin m_score = SAT_DEC; m_sat = 1; end
                else m_score = total;
                if (m_score > m_high) m_high = m_score;
                push_exp(c);
                if (slot_full) begin
                    cur_val = slot_val;
                    if (slot_edge < c) begin
                        cur_commit = c + 5; set_busy(c, c + 4, 1); slot_full = 0;
                    end else begin
                        // request taken in the commit cycle waits one idle cycle
                        cur_commit = c + 6; set_busy(c + 1, c + 5, 1); slot_release = c + 1;
                    end
                end else begin
                    cur_commit = -1;
                end
            end
        end
        if (c < MAXE) exp_drop[c] = m_drop;
        last_edge = c;
    endtask

    task automatic step(bit rs, bit cl, bit p, logic [3:0] v);
        rst_n = rs; clear = cl; add_pulse = p; add_value = v;
        model_edge(edge_cnt + 1, p, int'(v), cl, rs);
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 4'($urandom));
    endtask

    task automatic pump_to(int target);
        int d;
        while (m_score < target) begin
            d = target - m_score;
            step(1'b1, 1'b0, 1'b1, (d > 9) ? 4'd9 : 4'(d));
            idle(6);
        end
    endtask

    task automatic chk(string name, int e, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, e, got, exp);
        end
    endtask

    // monitor: pops an expectation on its commit edge, otherwise checks values hold
    initial begin : monitor
        logic [15:0] hs, hh;
        logic        hsat;
        exp_t        x;
        int          e;
        hs = 16'd0; hh = 16'd0; hsat = 1'b0;
        forever begin
            @(negedge CLK100MHZ);
            if (done) break;
            e = edge_cnt;
            if (e >= 1 && e <= last_edge && e < MAXE) begin
                while (sbq.size() > 0 && sbq[0].e < e) begin
                    x = sbq.pop_front();
                    checks++; errors++;
                    $display("FAIL stale_expectation at edge %0d: got edge %0d expected edge %0d", e, x.e, e);
                end
                if (sbq.size() > 0 && sbq[0].e == e) begin
                    x = sbq.pop_front();
                    hs = x.score; hh = x.high; hsat = x.sat;
                end
                chk("score", e, score, hs);
                chk("high_score", e, high_score, hh);
                chk("saturated", e, {15'd0, saturated}, {15'd0, hsat});
                chk("busy", e, {15'd0, busy}, {15'd0, exp_busy[e]});
                chk("drop_err", e, {15'd0, drop_err}, {15'd0, exp_drop[e]});
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'd5);
        idle(3);

        step(1'b1, 1'b0, 1'b1, 4'd7); idle(8);
        step(1'b1, 1'b0, 1'b1, 4'd7); idle(8);

        step(1'b1, 1'b1, 1'b0, 4'd0);
        pump_to(999);
        step(1'b1, 1'b0, 1'b1, 4'd1); idle(8);

        pump_to(9995);
        step(1'b1, 1'b0, 1'b1, 4'd9); idle(8);
        step(1'b1, 1'b0, 1'b1, 4'd0); idle(8);
        step(1'b1, 1'b1, 1'b0, 4'd0); idle(3);

        step(1'b1, 1'b0, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b1, 4'd2);
        step(1'b1, 1'b0, 1'b1, 4'd3);
        idle(14);

        step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 4'd5); idle(3);
        step(1'b1, 1'b1, 1'b1, 4'd4); idle(10);

        step(1'b1, 1'b0, 1'b1, 4'hF); idle(8);
        step(1'b1, 1'b0, 1'b1, 4'd5); idle(2);
        step(1'b0, 1'b0, 1'b1, 4'd3); idle(3);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 999);
            step(!(r < 4), (r >= 4 && r < 20), ($urandom_range(0, 9) < 4), 4'($urandom));
        end
        idle(20);

        done = 1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0 outstanding", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_bcd_counter.md
SCORE_BCD_COUNTER -- requirements
Module: score_bcd_counter

Interface
REQ-001 SHALL have parameter SAT_VALUE, default 16'h9999, BCD value the score is forced to on overflow.
REQ-002 SHALL have port CLK100MHZ  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port clear  input  1  new-game request, one-cycle pulse.
REQ-005 SHALL have port add_pulse  input  1  one-cycle request to add add_value to the score.
REQ-006 SHALL have port add_value  input  4  points to add, sampled only with add_pulse.
REQ-007 SHALL have port score  output  16  current score, 4 packed BCD digits, [3:0] least significant; drives the 7-segment controller directly.
REQ-008 SHALL have port high_score  output  16  highest committed score since reset, packed BCD.
REQ-009 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL have port saturated  output  1  sticky overflow flag.
REQ-011 SHALL have port drop_err  output  1  sticky lost-request flag.

Function
REQ-012 SHALL implement FSM states IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT.
REQ-013 SHALL clamp add_value >9 to 9 when latched; add_value 0 SHALL run the full sequence and leave score unchanged.
REQ-014 In IDLE, add_pulse SHALL latch the clamped value into the addend and move to ADD0 on the next edge.
REQ-015 ADDi SHALL add addend (ADD0 only) plus carry-in to working digit i, one digit per cycle: if sum >9, store sum-10 and carry=1; else store sum and carry=0.
REQ-016 Working register SHALL be loaded from score on entry to ADD0; score SHALL NOT change during ADD0..ADD3.
REQ-017 COMMIT SHALL write the working register to score in one cycle; if ADD3 produced carry-out, SHALL write SAT_VALUE instead and set saturated.
REQ-018 COMMIT SHALL load high_score with the committed value when it is strictly greater (unsigned compare of packed BCD).
REQ-019 Latency: add_pulse sampled at edge N, updated score and high_score SHALL be visible after edge N+6; busy high after edges N+1..N+5.
REQ-020 add_pulse while busy SHALL be stored in a one-entry pending slot (valid bit plus clamped value).
REQ-021 add_pulse while busy and pending slot full SHALL be discarded and set drop_err.
REQ-022 From COMMIT, if pending valid, FSM SHALL go to ADD0 with the pending value and clear the slot in the same edge; otherwise to IDLE.
REQ-023 add_pulse arriving in COMMIT with slot empty SHALL go into the slot (never lost, never merged).
REQ-024 Once saturated, further adds SHALL still run the sequence and commit SAT_VALUE.
REQ-025 clear SHALL, on the next edge: score=0, FSM=IDLE, pending slot emptied, saturated=0, drop_err=0; high_score retained.
REQ-026 clear SHALL take priority over add_pulse in the same cycle; that add_pulse is ignored.
REQ-027 clear mid-sequence SHALL abort the sequence with no commit.

Reset
REQ-028 rst_n low at a rising edge SHALL set score=0, high_score=0, busy=0, saturated=0, drop_err=0, pending empty, FSM=IDLE; rst_n overrides clear and add_pulse.
REQ-029 score SHALL only ever hold valid BCD digits (0-9) after reset.

Verification
REQ-030 From reset, add_pulse with add_value=7 twice (second after busy falls) -> score=16'h0014, high_score=16'h0014.
REQ-031 score=16'h0999, add 1 -> score stays 0999 during ADD0..ADD3, then 16'h1000 after edge N+6.
REQ-032 score=16'h9995, add 9 -> score=16'h9999, saturated=1; clear -> score=0, saturated=0, high_score=16'h9999.
REQ-033 Three add_pulse (values 1,2,3) on consecutive cycles from IDLE, score=0 -> first and second applied, third dropped, score=16'h0003, drop_err=1.
REQ-034 clear asserted in ADD2 with add_pulse in same cycle -> score=0, busy=0 next cycle, no later commit, high_score unchanged.
REQ-035 add_value=4'hF from score 0 -> score=16'h0009; rst_n low mid-sequence -> all outputs zero next edge.
